// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor with borrow-in: {b_out, diff} = a - b - b_in,
// one bit per clock, LSB first, behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_a_next;

  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // The minuend register doubles as the result register: each consumed
  // operand bit leaves at the LSB while the difference bit enters at the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_d;
    end else begin : g_wn
      assign w_a_next = {w_d, r_a[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_b_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= b_in;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_diff  <= w_a_next;
            r_b_out <= w_br_next;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state == RUN);
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_b_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 4, 1 and 16; expectations
// come from plain (WIDTH+1)-bit arithmetic on a - b - b_in.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s4, bi4, busy4, done4, bo4;
  logic [3:0]  a4, b4, d4;
  logic        s1, bi1, busy1, done1, bo1;
  logic [0:0]  a1, b1, d1;
  logic        s16, bi16, busy16, done16, bo16;
  logic [15:0] a16, b16, d16;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .b_in(bi4),
    .busy(busy4), .done(done4), .diff(d4), .b_out(bo4));
  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .b_in(bi1),
    .busy(busy1), .done(done1), .diff(d1), .b_out(bo1));
  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .b_in(bi16),
    .busy(busy16), .done(done16), .diff(d16), .b_out(bo16));

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]  q4[$];
  logic [1:0]  q1[$];
  logic [16:0] q16[$];
  logic [4:0]  exp4;
  logic [1:0]  exp1;
  logic [16:0] exp16;

  // Reference: a - b - b_in taken modulo 2^(w+1); top bit is the borrow.
  function automatic longint model(int w, longint a, longint b, longint bin);
    longint r;
    r = a - b - bin;
    return r & ((64'sd1 <<< (w + 1)) - 1);
  endfunction

  task automatic check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) fail("w4_unexpected_done");
      else begin
        exp4 = q4.pop_front();
        check("w4_result", {bo4, d4}, exp4);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) fail("w1_unexpected_done");
      else begin
        exp1 = q1.pop_front();
        check("w1_result", {bo1, d1}, exp1);
      end
    end
    if (done16 === 1'b1) begin
      if (q16.size() == 0) fail("w16_unexpected_done");
      else begin
        exp16 = q16.pop_front();
        check("w16_result", {bo16, d16}, exp16);
      end
    end
  end

  task automatic wait_idle4();
    int n = 0;
    while (busy4 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (busy4 !== 1'b0) fail("w4_idle_wait");
  endtask

  task automatic wait_done4();
    int n = 0;
    while (done4 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (done4 !== 1'b1) fail("w4_done_wait");
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue4(input int a, input int b, input int bi);
    wait_idle4();
    a4 = 4'(a); b4 = 4'(b); bi4 = 1'(bi); s4 = 1'b1;
    q4.push_back(5'(model(4, a, b, bi)));
    @(negedge clk);
    s4 = 1'b0;
  endtask

  task automatic count_busy4(output int nb);
    int n = 0;
    nb = 0;
    while (done4 !== 1'b1 && n < 50) begin
      if (busy4 === 1'b1) nb++;
      @(negedge clk); n++;
    end
    if (done4 !== 1'b1) fail("w4_done_wait");
  endtask

  task automatic count_dones4(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) nd++;
    end
  endtask

  task automatic issue1(input int a, input int b, input int bi);
    int n = 0;
    while (busy1 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (busy1 !== 1'b0) fail("w1_idle_wait");
    a1 = 1'(a); b1 = 1'(b); bi1 = 1'(bi); s1 = 1'b1;
    q1.push_back(2'(model(1, a, b, bi)));
    @(negedge clk);
    s1 = 1'b0;
  endtask

  task automatic issue16(input int a, input int b, input int bi);
    int n = 0;
    while (busy16 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (busy16 !== 1'b0) fail("w16_idle_wait");
    a16 = 16'(a); b16 = 16'(b); bi16 = 1'(bi); s16 = 1'b1;
    q16.push_back(17'(model(16, a, b, bi)));
    @(negedge clk);
    s16 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  int nb, nd, held;
  int t2_a[4]   = '{3, 0, 15, 15};
  int t2_b[4]   = '{9, 0, 15, 0};
  int t2_bi[4]  = '{0, 1, 1, 0};
  int t2_exp[4] = '{'h1A, 'h1F, 'h1F, 'h0F};

  initial begin
    rst_n = 1'b0;
    s4 = 0; a4 = 0; b4 = 0; bi4 = 0;
    s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    s16 = 0; a16 = 0; b16 = 0; bi16 = 0;
    #1;
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_diff", d4, 0);
    check("reset_b_out", bo4, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operation: busy for exactly WIDTH cycles, one done pulse.
    issue4(9, 3, 0);
    count_busy4(nb);
    check("t1_busy_cycles", nb, 4);
    check("t1_busy_at_done", busy4, 0);
    check("t1_value", {bo4, d4}, 'h06);
    @(negedge clk);
    check("t1_done_pulse_width", done4, 0);

    for (int i = 0; i < 4; i++) begin
      issue4(t2_a[i], t2_b[i], t2_bi[i]);
      wait_done4();
      check("t2_value", {bo4, d4}, t2_exp[i]);
    end

    // Start during RUN is ignored, as are operand changes after capture.
    issue4(9, 3, 0);
    s4 = 1'b1; a4 = 4'd1; b4 = 4'd2; bi4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0; a4 = 4'hF; b4 = 4'h0;
    wait_done4();
    check("t3_value", {bo4, d4}, 'h06);
    count_dones4(8, nd);
    check("t3_extra_done", nd, 0);

    // Start held high: back-to-back, new capture on the done cycle.
    wait_idle4();
    a4 = 4'd12; b4 = 4'd5; bi4 = 1'b0; s4 = 1'b1;
    q4.push_back(5'(model(4, 12, 5, 0)));
    wait_done4();
    a4 = 4'd7; b4 = 4'd2; bi4 = 1'b1;
    q4.push_back(5'(model(4, 7, 2, 1)));
    @(negedge clk);
    s4 = 1'b0;
    check("t4_no_gap", busy4, 1);
    held = 1; nb = 0;
    for (int n = 0; n < 50 && done4 !== 1'b1; n++) begin
      if (d4 !== 4'd7) held = 0;
      if (busy4 === 1'b1) nb++;
      @(negedge clk);
    end
    check("t4_diff_hold", held, 1);
    check("t4_busy_cycles", nb, 4);
    check("t4_value", {bo4, d4}, 'h04);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    issue4(9, 3, 0);
    @(negedge clk);
    rst_n = 1'b0;
    q4.delete();
    #1;
    check("t5_busy", busy4, 0);
    check("t5_done", done4, 0);
    check("t5_diff", d4, 0);
    check("t5_b_out", bo4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones4(10, nd);
    check("t5_no_done", nd, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          issue4(a, b, bi);
    wait_done4();
    @(negedge clk);

    // WIDTH=1: one RUN cycle per operation.
    issue1(0, 1, 0);
    check("w1_busy_one", busy1, 1);
    @(negedge clk);
    check("w1_done_next", done1, 1);
    for (int i = 0; i < 100; i++)
      issue1(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)));

    issue16(0, 'hFFFF, 1);
    issue16('hFFFF, 0, 0);
    issue16('hFFFF, 'hFFFF, 1);
    for (int i = 0; i < 150; i++)
      issue16(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 1)));

    repeat (25) @(negedge clk);
    check("w4_queue_drained", q4.size(), 0);
    check("w1_queue_drained", q1.size(), 0);
    check("w16_queue_drained", q16.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in, the inverse companion to the team's parallel full adder.
- Computes {b_out, diff} = a - b - b_in, one bit per clock, LSB first, behind a start/busy/done handshake.
- Used where area matters more than latency: multi-cycle datapaths and counter-compare logic.
- Result registers hold until the next operation completes.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy==0
a  input  WIDTH  minuend; captured on the accepted-start edge
b  input  WIDTH  subtrahend; captured on the accepted-start edge
b_in  input  1  borrow-in; captured on the accepted-start edge
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse; diff and b_out valid from this cycle
diff  output  WIDTH  (a - b - b_in) mod 2^WIDTH
b_out  output  1  1 iff a < b + b_in (unsigned)

Behaviour:
- Reset: asynchronous assert, synchronous-to-clk release.
  - While rst_n==0: state=IDLE, busy=0, done=0, diff=0, b_out=0, and all internal shift registers, bit counter and borrow register = 0.
- FSM states: IDLE and RUN.
  - IDLE: if start==1 at a rising edge, then on that edge: capture a, b, b_in into internal registers; clear the counter; go to RUN.
  - RUN: each edge processes bit i = counter value.
    - d_i = a_i ^ b_i ^ br.
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
    - d_i shifts into the result register from the MSB side; the operand registers shift right.
  - RUN, on the edge where counter==WIDTH-1:
    - Load diff with the completed result and b_out with br_next.
    - Set done=1 for the following cycle.
    - Return to IDLE.
- Outputs:
  - busy = (state==RUN); registered, no combinational path from start.
  - done is registered: high exactly one cycle, then low.
  - diff and b_out change only on the completion edge; otherwise they hold their values. Partial results are never visible.
- Latency: start accepted at edge k → busy=1 from edge k through k+WIDTH → done=1 and result valid after edge k+WIDTH.
  - Throughput is one operation per WIDTH cycles.
- Start handling:
  - start while busy==1 is ignored; no queuing, no error flag.
  - start held high continuously means back-to-back operations.
  - start asserted in the cycle done==1 (state IDLE) is accepted. New operands are captured while done is still high, and diff holds the previous result until the next completion.
  - Input changes on a, b, b_in after capture have no effect on the running operation.
- Width rules:
  - Internal arithmetic is strictly WIDTH bits plus a 1-bit borrow.
  - The counter is wide enough to reach WIDTH-1 (clog2(WIDTH), minimum 1 bit).
  - WIDTH==1: exactly one RUN cycle.
- Reset mid-operation: aborts immediately. All outputs return to reset values and no done pulse is generated for the aborted operation.

Test Plan:
1. WIDTH=4, a=9, b=3, b_in=0, single start pulse → busy high 4 cycles; done pulses once; diff=6, b_out=0.
2. a=3, b=9, b_in=0 → diff=10, b_out=1. Then a=0, b=0, b_in=1 → diff=15, b_out=1. Then a=15, b=15, b_in=1 → diff=15, b_out=1. Then a=15, b=0, b_in=0 → diff=15, b_out=0.
3. Start a=9, b=3; during RUN, pulse start with a=1, b=2 and change the a/b inputs → second start ignored; result diff=6, b_out=0; exactly one done pulse.
4. Start held high, operands changed to a=7, b=2, b_in=1 on the done cycle → first result delivered. The new operation begins with no idle gap; done after 4 more cycles with diff=4, b_out=0. diff stays at the old value until then.
5. Assert rst_n=0 two cycles into a RUN → busy, done, diff, b_out immediately 0. After release, no done pulse until a new start.
6. Exhaustive check at WIDTH=4 (all a, b, b_in) and random check at WIDTH=1 and WIDTH=16 → {b_out, diff} equals the reference a - b - b_in computed in WIDTH+1 bits, with borrow as the top bit.
